// File: rtl/twos_com_arbiter.sv
// Two-requester round-robin arbiter in front of a registered two's-complement unit.
// Each accepted request passes through IDLE -> CALC -> DONE and is acknowledged in DONE.
module twos_com_arbiter (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ0,
  input  logic [7:0] IN0,
  input  logic       NEG0,
  input  logic       REQ1,
  input  logic [7:0] IN1,
  input  logic       NEG1,
  output logic       ACK0,
  output logic       ACK1,
  output logic [7:0] RESULT,
  output logic       OVF,
  output logic       BUSY
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0] state;
  logic       pri;
  logic       winner;
  logic       neg_q;
  logic [7:0] opnd_q;
  logic       grant1;

  // PRI only matters on a tie; a lone request always wins.
  always_comb begin
    grant1 = REQ1;
    if (REQ0 && REQ1) grant1 = pri;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= IDLE;
      pri    <= 1'b0;
      winner <= 1'b0;
      neg_q  <= 1'b0;
      opnd_q <= '0;
      ACK0   <= 1'b0;
      ACK1   <= 1'b0;
      RESULT <= '0;
      OVF    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (REQ0 || REQ1) begin
            winner <= grant1;
            opnd_q <= grant1 ? IN1 : IN0;
            neg_q  <= grant1 ? NEG1 : NEG0;
            state  <= CALC;
          end
        end
        CALC: begin
          RESULT <= neg_q ? (~opnd_q + 8'd1) : opnd_q;
          OVF    <= neg_q && (opnd_q == 8'h80);
          ACK0   <= ~winner;
          ACK1   <= winner;
          state  <= DONE;
        end
        DONE: begin
          ACK0  <= 1'b0;
          ACK1  <= 1'b0;
          pri   <= ~winner;
          state <= IDLE;
        end
        default: begin
          ACK0  <= 1'b0;
          ACK1  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb BUSY = (state != IDLE);

endmodule

// File: tb/tb_twos_com_arbiter.sv
// Bench for twos_com_arbiter: directed cases plus random traffic, checked by a
// scoreboard fed from a transaction-level model of arbitration and negation.
module tb_twos_com_arbiter;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       REQ0 = 1'b0, REQ1 = 1'b0, NEG0 = 1'b0, NEG1 = 1'b0;
  logic [7:0] IN0 = '0, IN1 = '0;
  logic       ACK0, ACK1, OVF, BUSY;
  logic [7:0] RESULT;

  twos_com_arbiter dut (
    .CLK(CLK), .RESET(RESET),
    .REQ0(REQ0), .IN0(IN0), .NEG0(NEG0),
    .REQ1(REQ1), .IN1(IN1), .NEG1(NEG1),
    .ACK0(ACK0), .ACK1(ACK1), .RESULT(RESULT), .OVF(OVF), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       who;
    logic [7:0] res;
    logic       ovf;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic       pri_m = 1'b0;
  logic [7:0] last_res = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: every ACK pops the oldest expected completion.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!RESET && (ACK0 || ACK1)) begin
        check("ack_exclusive", {31'd0, ACK0 & ACK1}, 32'd0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: got ACK0=%0b ACK1=%0b, expected none", ACK0, ACK1);
        end else begin
          e = sb.pop_front();
          check("ack_who", {31'd0, ACK1}, {31'd0, e.who});
          check("result", {24'd0, RESULT}, {24'd0, e.res});
          check("ovf", {31'd0, OVF}, {31'd0, e.ovf});
        end
      end
    end
  end

  task automatic do_reset();
    RESET = 1'b1;
    #1;
    check("rst_busy", {31'd0, BUSY}, 32'd0);
    check("rst_acks", {30'd0, ACK1, ACK0}, 32'd0);
    check("rst_result", {24'd0, RESULT}, 32'd0);
    check("rst_ovf", {31'd0, OVF}, 32'd0);
    sb.delete();
    pri_m = 1'b0;
    last_res = '0;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  // One IDLE-edge worth of stimulus; the model decides the winner and answer.
  task automatic op(input logic r0, input logic [7:0] i0, input logic n0,
                    input logic r1, input logic [7:0] i1, input logic n1,
                    input logic hold);
    exp_t       e;
    logic [7:0] opnd;
    logic       ng;
    REQ0 = r0; IN0 = i0; NEG0 = n0;
    REQ1 = r1; IN1 = i1; NEG1 = n1;
    if (!(r0 || r1)) begin
      @(negedge CLK);
      check("idle_busy", {31'd0, BUSY}, 32'd0);
      check("idle_acks", {30'd0, ACK1, ACK0}, 32'd0);
      return;
    end
    e.who = (r0 && r1) ? pri_m : r1;
    opnd  = e.who ? i1 : i0;
    ng    = e.who ? n1 : n0;
    e.res = ng ? 8'((256 - int'(opnd)) % 256) : opnd;
    e.ovf = ng && (opnd == 8'h80);
    sb.push_back(e);
    @(negedge CLK);
    check("busy_calc", {31'd0, BUSY}, 32'd1);
    check("no_early_ack", {30'd0, ACK1, ACK0}, 32'd0);
    check("result_hold", {24'd0, RESULT}, {24'd0, last_res});
    IN0 = i0 ^ 8'h32; IN1 = i1 ^ 8'h32; NEG0 = ~n0; NEG1 = ~n1;
    if (!hold) begin REQ0 = 1'($urandom); REQ1 = 1'($urandom); end
    @(negedge CLK);
    check("busy_done", {31'd0, BUSY}, 32'd1);
    if (!hold) begin REQ0 = 1'($urandom); REQ1 = 1'($urandom); end
    @(negedge CLK);
    check("busy_idle", {31'd0, BUSY}, 32'd0);
    check("ack_clear", {30'd0, ACK1, ACK0}, 32'd0);
    check("result_keep", {24'd0, RESULT}, {24'd0, e.res});
    last_res = e.res;
    pri_m = ~e.who;
  endtask

  initial begin : stim
    do_reset();
    op(1'b1, 8'h05, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    op(1'b0, 8'h00, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0);
    op(1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    do_reset();
    for (int unsigned k = 0; k < 3; k++)
      op(1'b1, 8'h01, 1'b1, 1'b1, 8'h03, 1'b1, 1'b1);
    op(1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    op(1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    op(1'b1, 8'h01, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    op(1'b1, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    op(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Abort a requester-1 operation mid-flight.
    op(1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    REQ0 = 1'b0; REQ1 = 1'b1; IN1 = 8'h7E; NEG1 = 1'b1;
    @(negedge CLK);
    check("abort_busy", {31'd0, BUSY}, 32'd1);
    REQ1 = 1'b0;
    do_reset();
    check("abort_no_ack", {30'd0, ACK1, ACK0}, 32'd0);
    check("abort_result", {24'd0, RESULT}, 32'd0);
    op(1'b1, 8'h02, 1'b1, 1'b1, 8'h04, 1'b1, 1'b0);

    for (int unsigned k = 0; k < 300; k++) begin
      if ($urandom_range(7) == 0)
        op(1'b0, 8'($urandom), 1'($urandom), 1'b0, 8'($urandom), 1'($urandom), 1'b0);
      else
        op(1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 8'($urandom),
           1'($urandom), 1'($urandom));
    end
    REQ0 = 1'b0; REQ1 = 1'b0;
    @(negedge CLK);
    check("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL timeout: simulation still running, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

endmodule
